fifo_buffer: RTL and testbench

FIFO_BUFFER -- requirements
Module: fifo_buffer

---
 rtl/fifo_buffer.sv | 62 ++++++
 tb/tb_fifo_buffer.sv | 113 +++++++++++
 2 files changed

// File: rtl/fifo_buffer.sv
// fifo_buffer: circular-buffer FIFO with registered read, occupancy flags and sticky error tracking.
module fifo_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       fifo_full,
  output logic                       fifo_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       err_sticky,
  input  logic                       clr_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic push_ok, pop_ok, ovf_ev, unf_ev;
  logic [CW-1:0] cnt_n;
  always_comb begin
    push_ok = push & (~fifo_full | pop);
    pop_ok  = pop & ~fifo_empty;
    ovf_ev  = push & fifo_full & ~pop;
    unf_ev  = pop & fifo_empty;
    cnt_n   = count + CW'(push_ok) - CW'(pop_ok);
  end
  always_ff @(posedge clk)
    if (push_ok) mem[wp] <= wr_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp         <= '0;
      rp         <= '0;
      count      <= '0;
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      wp         <= push_ok ? wp + AW'(1) : wp;
      rp         <= pop_ok ? rp + AW'(1) : rp;
      rd_data    <= pop_ok ? mem[rp] : rd_data;
      rd_valid   <= pop_ok;
      count      <= cnt_n;
      fifo_full  <= cnt_n == CW'(DEPTH);
      fifo_empty <= cnt_n == '0;
      overflow   <= ovf_ev;
      underflow  <= unf_ev;
      // a new error outranks a simultaneous clear
      err_sticky <= ovf_ev | unf_ev | (err_sticky & ~clr_err);
    end
  end
endmodule

// File: tb/tb_fifo_buffer.sv
// tb_fifo_buffer: randomized scoreboard bench for fifo_buffer against a queue-based reference model.
module tb_fifo_buffer;
  localparam int DW = 8;
  localparam int DEPTH = 8;
  logic clk = 0, rst_n = 1, push = 0, pop = 0, clr_err = 0;
  logic [DW-1:0] wr_data = '0, rd_data;
  logic rd_valid, fifo_full, fifo_empty, overflow, underflow, err_sticky;
  logic [$clog2(DEPTH):0] count;
  int checks = 0, failures = 0;
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_rd = '0;
  bit err_m = 0, eovf = 0, eunf = 0, erv = 0;

  fifo_buffer #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .wr_data(wr_data), .pop(pop),
    .rd_data(rd_data), .rd_valid(rd_valid), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .count(count), .overflow(overflow), .underflow(underflow), .err_sticky(err_sticky),
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_rd_valid", 1, 0);
      else chk("scoreboard_rd_data", int'(rd_data), int'(exp_q.pop_front()));
    end
  end

  task automatic step(input bit pu, input logic [DW-1:0] d, input bit po, input bit cl);
    bit full, empty, pa, pp;
    push = pu; wr_data = d; pop = po; clr_err = cl;
    full = mq.size() == DEPTH;
    empty = mq.size() == 0;
    pa = pu && (!full || po);
    pp = po && !empty;
    if (pp) begin
      last_rd = mq.pop_front();
      exp_q.push_back(last_rd);
    end
    if (pa) mq.push_back(d);
    eovf = pu && full && !po;
    eunf = po && empty;
    erv = pp;
    err_m = (eovf || eunf) ? 1'b1 : (cl ? 1'b0 : err_m);
    @(posedge clk);
    #1;
    chk("count", int'(count), mq.size());
    chk("fifo_full", int'(fifo_full), int'(mq.size() == DEPTH));
    chk("fifo_empty", int'(fifo_empty), int'(mq.size() == 0));
    chk("overflow", int'(overflow), int'(eovf));
    chk("underflow", int'(underflow), int'(eunf));
    chk("err_sticky", int'(err_sticky), int'(err_m));
    chk("rd_valid", int'(rd_valid), int'(erv));
    chk("rd_data_hold", int'(rd_data), int'(last_rd));
    push = 0; pop = 0; clr_err = 0;
  endtask

  task automatic chk_reset_state(input string n);
    chk({n, "_count"}, int'(count), 0);
    chk({n, "_empty"}, int'(fifo_empty), 1);
    chk({n, "_full"}, int'(fifo_full), 0);
    chk({n, "_pulses"}, int'({rd_valid, overflow, underflow, err_sticky}), 0);
    chk({n, "_rd_data"}, int'(rd_data), 0);
  endtask

  initial begin
    #2 rst_n = 0;
    #1 chk_reset_state("reset");
    #19 rst_n = 1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 8'h11 + 8'(i), 0, 0);
    step(1, 8'h99, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    step(1, 8'h3C, 1, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(1, 8'($urandom), 0, 0);
    step(1, 8'hA5, 1, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 8'($urandom), 0, 0);
    for (int i = 0; i < 20; i++) step(1, 8'($urandom), 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
    while (mq.size() > 0) step(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 8'($urandom), 0, 0);
    @(posedge clk);
    #3 rst_n = 0;
    #1 chk_reset_state("midclk_reset");
    mq.delete();
    last_rd = '0;
    err_m = 0;
    #3 rst_n = 1;
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
